flit_out_arb: RTL and testbench

- Credit-based round-robin arbiter that shares the node's single NI output link between N local flit sources, e.g. the spike/config output FIFO and the config read-response path.
- Multi-flit DATA packets hold the grant until their DATA_END flit is sent, so flits of one packet are never interleaved with another source's flits.
- Sits between the source FIFOs' pop interfaces and the node-top flit_out/credit_in port.

---
 rtl/flit_out_arb.sv | 113 +++++++++++
 tb/tb_flit_out_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_out_arb.sv
// flit_out_arb: credit-based round-robin arbiter sharing one NI output link, holding the grant for DATA packets
//
// Parameters: N sources, IW index width, FW flit width, FTW type width (flit[FW-1 -: FTW]), B credit counter width.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   src_valid    per-source head-flit valid
//   src_flit     per-source head flit, source i at [i*FW +: FW]
//   src_ready    one-hot pop strobe, asserted in the accepting cycle
//   credit_in    one credit returned by the NI
//   flit_out_wr  registered valid strobe for flit_out
//   flit_out     registered outgoing flit
//   grant_idx    index of the last granted source
//   locked       a multi-flit packet is in progress
//   credit_err   sticky credit overflow flag
module flit_out_arb #(
  parameter int N   = 2,
  parameter int IW  = 1,
  parameter int FW  = 59,
  parameter int FTW = 3,
  parameter int B   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    src_valid,
  input  logic [N*FW-1:0] src_flit,
  output logic [N-1:0]    src_ready,
  input  logic            credit_in,
  output logic            flit_out_wr,
  output logic [FW-1:0]   flit_out,
  output logic [IW-1:0]   grant_idx,
  output logic            locked,
  output logic            credit_err
);
  typedef enum logic {S_IDLE, S_LOCK} state_t;
  localparam logic [FTW-1:0] T_DATA = FTW'(1);
  localparam logic [FTW-1:0] T_END  = FTW'(2);
  localparam logic [B-1:0]   CNT_MAX = '1;
  localparam logic [N-1:0]   ONE = N'(1);
  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, grant_q, grant_d, rr_win, g;
  logic [B-1:0]  cnt_q, cnt_d;
  logic [FW-1:0] flit_q, flit_d, win_flit;
  logic [FTW-1:0] win_type;
  logic          wr_q, err_q, err_d, avail, fire, hit;
  // (i + k) mod N for k < N, valid for non-power-of-two N
  function automatic logic [IW-1:0] idx(input logic [IW-1:0] i, input int k);
    int v;
    v = int'(i) + k;
    return IW'((v >= N) ? v - N : v);
  endfunction
  // first valid source at or after rr_ptr, wrapping
  always_comb begin
    rr_win = rr_ptr_q;
    hit = 1'b0;
    for (int k = 0; k < N; k++)
      if (!hit && src_valid[idx(rr_ptr_q, k)]) begin
        hit = 1'b1;
        rr_win = idx(rr_ptr_q, k);
      end
  end
  // avail comes from the registered count, so credit_in never reaches src_ready
  assign avail     = cnt_q != '0;
  assign g         = (state_q == S_LOCK) ? lock_idx_q : rr_win;
  assign fire      = avail & ((state_q == S_LOCK) ? src_valid[lock_idx_q] : |src_valid);
  assign src_ready = fire ? ONE << g : '0;
  assign win_flit  = src_flit[g*FW +: FW];
  assign win_type  = win_flit[FW-1 -: FTW];
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (fire && state_q == S_IDLE && win_type == T_DATA) begin
      state_d    = S_LOCK;
      lock_idx_d = g;
    end else if (fire && state_q == S_IDLE) begin
      rr_ptr_d = idx(g, 1);
    end else if (fire && win_type == T_END) begin
      state_d  = S_IDLE;
      rr_ptr_d = idx(lock_idx_q, 1);
    end
  end
  // simultaneous fire and credit cancel; a credit at full count is an overflow
  assign cnt_d   = (fire && !credit_in) ? cnt_q - B'(1)
                 : (credit_in && !fire && cnt_q != CNT_MAX) ? cnt_q + B'(1) : cnt_q;
  assign err_d   = err_q | (credit_in & ~fire & (cnt_q == CNT_MAX));
  assign flit_d  = fire ? win_flit : flit_q;
  assign grant_d = fire ? g : grant_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      grant_q    <= '0;
      cnt_q      <= CNT_MAX;
      flit_q     <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      flit_q     <= flit_d;
      wr_q       <= fire;
      err_q      <= err_d;
    end
  assign flit_out_wr = wr_q;
  assign flit_out    = flit_q;
  assign grant_idx   = grant_q;
  assign locked      = state_q == S_LOCK;
  assign credit_err  = err_q;
endmodule

// File: tb/tb_flit_out_arb.sv
// tb_flit_out_arb: scoreboard bench for flit_out_arb
module tb_flit_out_arb;
  localparam int N = 2, IW = 1, FW = 59;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*FW-1:0] src_flit = '0;
  logic [N-1:0]    src_ready;
  logic            credit_in = 1'b0;
  logic            flit_out_wr;
  logic [FW-1:0]   flit_out;
  logic [IW-1:0]   grant_idx;
  logic            locked;
  logic            credit_err;
  int tests = 0, fails = 0;
  logic [IW+FW-1:0] exp_q[$];
  always #5 clk = ~clk;
  flit_out_arb #(.N(N), .IW(IW), .FW(FW), .FTW(3), .B(4)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_flit(src_flit),
    .src_ready(src_ready), .credit_in(credit_in), .flit_out_wr(flit_out_wr),
    .flit_out(flit_out), .grant_idx(grant_idx), .locked(locked), .credit_err(credit_err)
  );
  function automatic logic [FW-1:0] mk(input logic [2:0] t, input logic [55:0] p);
    return {t, p};
  endfunction
  // output side of the scoreboard: every written flit must match the oldest expectation
  always @(negedge clk)
    if (rst_n && flit_out_wr) begin
      logic [IW+FW-1:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got idx %0d flit %h, expected no flit", grant_idx, flit_out);
      end else begin
        e = exp_q.pop_front();
        if ({grant_idx, flit_out} !== e) begin
          fails++;
          $display("FAIL out_flit: got idx %0d flit %h, expected idx %0d flit %h",
                   grant_idx, flit_out, e[FW], e[FW-1:0]);
        end
      end
    end
  task automatic drive(input logic [1:0] v, input logic [FW-1:0] f0, input logic [FW-1:0] f1, input logic c);
    @(negedge clk);
    src_valid = v;
    src_flit  = {f1, f0};
    credit_in = c;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    src_valid = '0;
    src_flit  = '0;
    credit_in = 1'b0;
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_flits: got %0d undelivered, expected 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({flit_out_wr, flit_out, grant_idx, locked, credit_err, src_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got wr=%b flit=%h idx=%0d locked=%b err=%b ready=%b, expected all 0",
               flit_out_wr, flit_out, grant_idx, locked, credit_err, src_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    logic [FW-1:0] f;
    f = mk(3'b000, 56'h0000_0012_3456);
    do_reset();
    drive(2'b01, f, '0, 1'b0);
    tests++;
    if (src_ready !== 2'b01) begin
      fails++;
      $display("FAIL single_ready: got %b, expected 01", src_ready);
    end
    exp_q.push_back({1'b0, f});
    drive(2'b00, '0, '0, 1'b0);
    tests++;
    if (flit_out_wr !== 1'b1 || src_ready !== 2'b00) begin
      fails++;
      $display("FAIL single_wr: got wr=%b ready=%b, expected wr=1 ready=00", flit_out_wr, src_ready);
    end
    drive(2'b00, '0, '0, 1'b0);
  endtask
  task automatic test_round_robin();
    logic [FW-1:0] f0, f1;
    logic [1:0] e;
    f0 = mk(3'b000, 56'hA0);
    f1 = mk(3'b000, 56'hB1);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, f0, f1, 1'b0);
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if (src_ready !== e) begin
        fails++;
        $display("FAIL rr_ready[%0d]: got %b, expected %b", k, src_ready, e);
      end
      exp_q.push_back((k % 2 == 0) ? {1'b0, f0} : {1'b1, f1});
      if (k > 0) begin
        tests++;
        if (flit_out_wr !== 1'b1) begin
          fails++;
          $display("FAIL rr_wr[%0d]: got %b, expected 1", k, flit_out_wr);
        end
      end
    end
    drive(2'b00, '0, '0, 1'b0);
  endtask
  task automatic test_packet();
    logic [FW-1:0] f1;
    logic [1:0] v[6]  = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00};
    logic [2:0] t[6]  = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b000, 3'b000};
    logic [1:0] er[6] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    logic       el[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [FW-1:0] f0;
    f1 = mk(3'b000, 56'hB1);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      f0 = mk(t[k], 56'(k + 32'hD0));
      drive(v[k], f0, f1, 1'b0);
      tests++;
      if (src_ready !== er[k] || locked !== el[k]) begin
        fails++;
        $display("FAIL pkt[%0d]: got ready=%b locked=%b, expected ready=%b locked=%b",
                 k, src_ready, locked, er[k], el[k]);
      end
      if (er[k] == 2'b01) exp_q.push_back({1'b0, f0});
      if (er[k] == 2'b10) exp_q.push_back({1'b1, f1});
    end
  endtask
  task automatic test_credit_stall();
    logic [FW-1:0] f;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      f = mk(3'b000, 56'(k + 256));
      drive(2'b01, f, '0, 1'b0);
      tests++;
      if (src_ready !== 2'b01) begin
        fails++;
        $display("FAIL credit_fire[%0d]: got %b, expected 01", k, src_ready);
      end
      exp_q.push_back({1'b0, f});
    end
    f = mk(3'b000, 56'h200);
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, f, '0, k == 2);
      tests++;
      if (src_ready !== 2'b00) begin
        fails++;
        $display("FAIL credit_stall[%0d]: got %b, expected 00", k, src_ready);
      end
    end
    drive(2'b01, f, '0, 1'b0);
    tests++;
    if (src_ready !== 2'b01) begin
      fails++;
      $display("FAIL credit_resume: got %b, expected 01", src_ready);
    end
    exp_q.push_back({1'b0, f});
    drive(2'b01, f, '0, 1'b0);
    tests++;
    if (src_ready !== 2'b00 || credit_err !== 1'b0) begin
      fails++;
      $display("FAIL credit_restall: got ready=%b err=%b, expected ready=00 err=0", src_ready, credit_err);
    end
    drive(2'b00, '0, '0, 1'b0);
  endtask
  task automatic test_credit_err();
    logic [FW-1:0] f;
    f = mk(3'b000, 56'hC0);
    do_reset();
    drive(2'b01, f, '0, 1'b1);
    exp_q.push_back({1'b0, f});
    drive(2'b00, '0, '0, 1'b0);
    tests++;
    if (credit_err !== 1'b0) begin
      fails++;
      $display("FAIL err_fire_credit: got %b, expected 0", credit_err);
    end
    drive(2'b00, '0, '0, 1'b1);
    drive(2'b00, '0, '0, 1'b0);
    tests++;
    if (credit_err !== 1'b1) begin
      fails++;
      $display("FAIL err_set: got %b, expected 1", credit_err);
    end
    repeat (3) drive(2'b00, '0, '0, 1'b0);
    tests++;
    if (credit_err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got %b, expected 1", credit_err);
    end
    do_reset();
    tests++;
    if (credit_err !== 1'b0) begin
      fails++;
      $display("FAIL err_reset: got %b, expected 0", credit_err);
    end
  endtask
  task automatic test_reset_in_lock();
    logic [FW-1:0] d, s;
    d = mk(3'b001, 56'hE0);
    s = mk(3'b000, 56'hE1);
    do_reset();
    drive(2'b01, d, '0, 1'b0);
    exp_q.push_back({1'b0, d});
    drive(2'b00, '0, '0, 1'b0);
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL lock_entered: got %b, expected 1", locked);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (locked !== 1'b0 || flit_out_wr !== 1'b0) begin
      fails++;
      $display("FAIL lock_async_reset: got locked=%b wr=%b, expected 0 0", locked, flit_out_wr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b10, '0, s, 1'b0);
    tests++;
    if (src_ready !== 2'b10) begin
      fails++;
      $display("FAIL post_reset_grant: got %b, expected 10", src_ready);
    end
    exp_q.push_back({1'b1, s});
    drive(2'b00, '0, '0, 1'b0);
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_packet();
    test_credit_stall();
    test_credit_err();
    test_reset_in_lock();
    repeat (3) drive(2'b00, '0, '0, 1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_pending: got %0d undelivered, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
